// File: rtl/ram_ctrl_if.sv
// Request, write-stream and read-stream signals between a datapath master and ram_ctrl.
// master drives requests/write beats/read consume; slave (ram_ctrl) drives readies, read data and status.
interface ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready,
    input  req_ready, wr_ready, rd_valid, rd_data, done, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready,
    output req_ready, wr_ready, rd_valid, rd_data, done, busy
  );
endinterface

// File: rtl/ram_ctrl.sv
// Burst controller for a single-port synchronous RAM: 1 write beat/cycle; read beat appears 3 cycles after issue.
// Write beats stall via wr_ready (only high in WR); read data is held in RD_OUT until rd_ready.
module ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 128
) (
  input  logic              CLK,
  input  logic              RST,
  ram_ctrl_if.slave         bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, RD_OUT, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cur, cur_n, cur_inc, req_loc;
  logic [7:0]        cnt, cnt_n;
  logic              en_n, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] din_n, rdq, rdq_n;

  assign cur_inc = (cur == CW'(DEPTH - 1)) ? '0 : cur + CW'(1);
  assign req_loc = CW'(32'(bus.req_addr) % 32'(DEPTH));

  assign bus.req_ready = (state == IDLE);
  assign bus.wr_ready  = (state == WR);
  assign bus.rd_valid  = (state == RD_OUT);
  assign bus.rd_data   = rdq;
  assign bus.done      = (state == DONE);
  assign bus.busy      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cur      <= '0;
      cnt      <= '0;
      ram_en   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdq      <= '0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      cnt      <= cnt_n;
      ram_en   <= en_n;
      ram_we   <= we_n;
      ram_addr <= addr_n;
      ram_din  <= din_n;
      rdq      <= rdq_n;
    end
  end

  // RAM strobes are single-cycle: en/we fall back to 0 unless a beat is issued this cycle.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    cnt_n   = cnt;
    en_n    = 1'b0;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    din_n   = ram_din;
    rdq_n   = rdq;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cur_n   = req_loc;
          cnt_n   = bus.req_len;
          en_n    = 1'b1;
          addr_n  = ADDR_W'(req_loc);
          state_n = bus.req_we ? WR : RD_REQ;
        end
      end
      WR: begin
        if (bus.wr_valid) begin
          en_n   = 1'b1;
          we_n   = 1'b1;
          addr_n = ADDR_W'(cur);
          din_n  = bus.wr_data;
          cur_n  = cur_inc;
          if (cnt == 8'd0) state_n = DONE;
          else             cnt_n   = cnt - 8'd1;
        end
      end
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: begin
        rdq_n   = ram_dout;
        state_n = RD_OUT;
      end
      RD_OUT: begin
        if (bus.rd_ready) begin
          if (cnt == 8'd0) begin
            state_n = DONE;
          end else begin
            cur_n   = cur_inc;
            cnt_n   = cnt - 8'd1;
            en_n    = 1'b1;
            addr_n  = ADDR_W'(cur_inc);
            state_n = RD_REQ;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: RAM model, burst-level reference model compared every cycle, plus directed literal checks.
module tb_ram_ctrl;
  logic       CLK = 1'b0;
  logic       RST;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic [7:0] mem [128];

  ram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128)) dut (
    .CLK(CLK), .RST(RST), .bus(bus),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 CLK = ~CLK;

  // 128x8 single-port RAM with one-cycle read latency.
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr[6:0]] <= ram_din;
      else        ram_dout <= mem[ram_addr[6:0]];
    end
  end

  int chk = 0, fails = 0;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    chk++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Burst-level model: what the bus and RAM ports must show in the current cycle.
  logic [7:0] ref_mem [128];
  bit         ref_vld [128];
  bit         m_known = 0, m_active = 0, m_done = 0, m_we = 0, m_s_en = 0, m_s_we = 0;
  logic [6:0] m_addr = '0, m_s_addr = '0;
  logic [7:0] m_s_din = '0;
  int         m_left = 0, m_rd_wait = 0;
  bit         hs_req, hs_wr, hs_rd;
  logic [7:0] last_rd;
  int         done_seen = 0, strobe_cnt = 0, wl_n = 0, lat;
  logic [7:0] wr_log [64];
  logic [7:0] got [4];

  task automatic cycle();
    bit exp_rv, n_en, n_we;
    logic [6:0] n_addr;
    logic [7:0] n_din;
    @(negedge CLK);
    exp_rv = m_active && !m_we && !m_done && (m_rd_wait == 0);
    hs_req = 0; hs_wr = 0; hs_rd = 0;
    if (m_known) begin
      check("req_ready", bus.req_ready, !m_active);
      check("busy", bus.busy, m_active);
      check("done", bus.done, m_done);
      check("wr_ready", bus.wr_ready, m_active && m_we && !m_done);
      check("rd_valid", bus.rd_valid, exp_rv);
      if (exp_rv) check("rd_data", bus.rd_data, ref_mem[m_addr]);
      check("ram_en", ram_en, m_s_en);
      check("ram_we", ram_we, m_s_en && m_s_we);
      check("ram_addr_msb", ram_addr[7], 0);
      if (m_s_en) check("ram_addr", ram_addr, {1'b0, m_s_addr});
      if (m_s_en && m_s_we) check("ram_din", ram_din, m_s_din);
    end
    if (bus.done) done_seen++;
    if (ram_en && !ram_we) strobe_cnt++;
    if (ram_en && ram_we && wl_n < 64) begin wr_log[wl_n] = ram_addr; wl_n++; end
    if (bus.rd_valid && bus.rd_ready) last_rd = bus.rd_data;
    n_en = 0; n_we = 0; n_addr = m_s_addr; n_din = m_s_din;
    if (RST) begin
      m_known = 1; m_active = 0; m_done = 0; m_rd_wait = 0; n_addr = '0; n_din = '0;
    end else if (m_known) begin
      if (m_done) begin
        m_done = 0; m_active = 0;
      end else if (!m_active) begin
        if (bus.req_valid) begin
          hs_req = 1; m_active = 1; m_we = bus.req_we;
          m_addr = 7'(bus.req_addr % 128); m_left = int'(bus.req_len) + 1;
          n_en = 1; n_addr = m_addr; m_rd_wait = 2;
        end
      end else if (m_we) begin
        if (bus.wr_valid) begin
          hs_wr = 1;
          ref_mem[m_addr] = bus.wr_data; ref_vld[m_addr] = 1;
          n_en = 1; n_we = 1; n_addr = m_addr; n_din = bus.wr_data;
          m_addr = 7'((int'(m_addr) + 1) % 128);
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end else if (m_rd_wait > 0) begin
        m_rd_wait--;
      end else if (bus.rd_ready) begin
        hs_rd = 1; m_left--;
        if (m_left == 0) m_done = 1;
        else begin
          m_addr = 7'((int'(m_addr) + 1) % 128);
          n_en = 1; n_addr = m_addr; m_rd_wait = 2;
        end
      end
    end
    m_s_en = n_en; m_s_we = n_we; m_s_addr = n_addr; m_s_din = n_din;
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin cycle(); n++; end
    check("idle_reached", bus.busy, 0);
  endtask

  task automatic req(input bit we, input logic [7:0] addr, input logic [7:0] len);
    int n = 0;
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = addr; bus.req_len = len;
    do begin cycle(); n++; end while (!hs_req && n < 20);
    check("req_handshake", hs_req, 1);
    bus.req_valid = 0;
  endtask

  task automatic write_burst(input logic [7:0] addr, input int len,
                             input logic [7:0] d0, d1, d2, d3, input int abort_at);
    logic [7:0] d [4];
    int dn0, n;
    d = '{d0, d1, d2, d3};
    dn0 = done_seen;
    req(1, addr, 8'(len));
    for (int i = 0; i <= len; i++) begin
      if (abort_at != 0 && i == abort_at) begin
        RST = 1; cycle(); RST = 0;
        check("no_done_on_abort", done_seen - dn0, 0);
        return;
      end
      bus.wr_valid = 1; bus.wr_data = d[i]; n = 0;
      do begin cycle(); n++; end while (!hs_wr && n < 20);
      check("wr_handshake", hs_wr, 1);
      bus.wr_valid = 0;
    end
    wait_idle();
    check("wr_done_once", done_seen - dn0, 1);
  endtask

  task automatic read_burst(input logic [7:0] addr, input int len, input int stall);
    int s0, dn0, n;
    s0 = strobe_cnt; dn0 = done_seen;
    req(0, addr, 8'(len));
    lat = 1;
    while (!bus.rd_valid && lat < 10) begin cycle(); lat++; end
    for (int b = 0; b <= len; b++) begin
      if (b == 0 && stall > 0) begin
        bus.rd_ready = 0;
        repeat (stall) cycle();
      end
      bus.rd_ready = 1; n = 0;
      do begin cycle(); n++; end while (!hs_rd && n < 20);
      check("rd_handshake", hs_rd, 1);
      got[b] = last_rd;
      bus.rd_ready = 0;
    end
    wait_idle();
    check("rd_done_once", done_seen - dn0, 1);
    check("rd_strobes", strobe_cnt - s0, len + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e3 [4];
    int wl0, dn0, bad;
    RST = 1;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;
    for (int i = 0; i < 128; i++) ref_vld[i] = 0;

    // 1: reset state
    cycle(); cycle();
    RST = 0;
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rd_data", bus.rd_data, 0);

    // 2: single-beat write then read, latency 3
    write_burst(8'h10, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 0);
    read_burst(8'h10, 0, 0);
    check("t2_rd_data", got[0], 8'hA5);
    check("t2_rd_latency", lat, 3);

    // 3: wrapping 4-beat write and read-back
    wl0 = wl_n;
    write_burst(8'h7E, 3, 8'h11, 8'h22, 8'h33, 8'h44, 0);
    e3 = '{8'h7E, 8'h7F, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) check("t3_wr_addr", wr_log[wl0 + i], e3[i]);
    read_burst(8'h7E, 3, 0);
    e3 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) check("t3_rd_data", got[i], e3[i]);

    // 4: out-of-range request address folds modulo 128
    write_burst(8'h85, 0, 8'h5A, 8'h00, 8'h00, 8'h00, 0);
    check("t4_mem5", mem[5], 8'h5A);
    read_burst(8'h05, 0, 0);
    check("t4_rd_data", got[0], 8'h5A);

    // 5: read with consumer stalled 5 cycles
    read_burst(8'h7E, 3, 5);
    check("t5_rd_first", got[0], 8'h11);
    check("t5_rd_last", got[3], 8'h44);

    // 6: reset during beat 2 of a 4-beat write
    write_burst(8'h40, 3, 8'h01, 8'h02, 8'h03, 8'h04, 0);
    dn0 = done_seen;
    write_burst(8'h40, 3, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 2);
    repeat (3) cycle();
    check("t6_busy", bus.busy, 0);
    check("t6_req_ready", bus.req_ready, 1);
    check("t6_done_none", done_seen - dn0, 0);
    check("t6_mem40", mem[8'h40], 8'hC1);
    check("t6_mem41", mem[8'h41], 8'hC2);
    check("t6_mem42", mem[8'h42], 8'h03);
    check("t6_mem43", mem[8'h43], 8'h04);
    read_burst(8'h40, 3, 0);
    e3 = '{8'hC1, 8'hC2, 8'h03, 8'h04};
    for (int i = 0; i < 4; i++) check("t6_rd_data", got[i], e3[i]);

    bad = 0;
    for (int i = 0; i < 128; i++) if (ref_vld[i] && mem[i] !== ref_mem[i]) bad++;
    check("mem_vs_model", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule
